vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Transaction controller for the vending machine.
- Accumulates coin credit, validates a product selection against its price, and sequences the dispenser over a req/ack handshake.
- Then pays change coin by coin to the change hopper over a second req/ack handshake.
- Sits between the coin/keypad front end and the dispense/return mechanics.

Parameters:
- COIN0_VAL, 5: value of coin code 3'b001
- COIN1_VAL, 10: value of coin code 3'b010
- COIN2_VAL, 25: value of coin code 3'b100
- PRICE0, 15: price of product 0 (choice=0)
- PRICE1, 20: price of product 1 (choice=1)
- CREDIT_W, 8: credit register width
- MAX_CREDIT, 100: highest credit accepted
- DISP_TIMEOUT, 64: cycles to wait for disp_ack before fault

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- coin  in  3  one-hot coin strobe, valid for one cycle; 3'b000 = none
- coin_reject  out  1  one-cycle pulse: coin not accepted, returned mechanically
- vend_req  in  1  one-cycle selection strobe
- choice  in  1  product select, sampled with vend_req
- cancel  in  1  one-cycle refund request
- disp_req  out  1  dispense request, held until disp_ack
- disp_sel  out  1  product being dispensed, stable while disp_req=1
- disp_ack  in  1  dispenser done
- hop_req  out  1  change-coin request, held until hop_ack
- ret  out  3  one-hot coin to return, stable while hop_req=1
- hop_ack  in  1  hopper released the coin
- credit  out  CREDIT_W  current credit
- busy  out  1  high in any state other than IDLE
- vend_done  out  1  one-cycle pulse when a sale finishes (after last change coin)
- fault  out  1  sticky: dispense timeout occurred; cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE, credit=0, all outputs 0, timeout counter 0, fault=0. Reset mid-transaction abandons it; credit is lost.
- States: IDLE, DISP_WAIT, CHG_ISSUE, CHG_WAIT, CHG_GAP.
- IDLE, coin accept: a valid one-hot coin with credit+value <= MAX_CREDIT adds its value to credit on the next edge.
- IDLE, coin reject: a non-one-hot nonzero coin, or one that would exceed MAX_CREDIT, gives coin_reject=1 for one cycle and leaves credit unchanged.
- IDLE, priority within one cycle: cancel > vend_req > coin.
- Any coin arriving in the same cycle as an accepted cancel or vend_req is rejected.
- Any coin arriving while busy=1 is rejected.
- cancel in IDLE with credit>0 -> CHG_ISSUE (refund all). With credit=0, cancel is ignored.
- vend_req with credit >= price(choice):
  - credit <= credit - price.
  - disp_sel <= choice, disp_req <= 1.
  - -> DISP_WAIT.
- vend_req with credit < price: ignored, no state change.
- DISP_WAIT: counts cycles.
  - disp_ack=1 -> drop disp_req next edge, go to CHG_ISSUE if credit>0, else pulse vend_done and return to IDLE.
  - Count reaches DISP_TIMEOUT without disp_ack -> drop disp_req, set fault, restore price to credit, go to CHG_ISSUE (full refund, no vend_done).
- CHG_ISSUE: pick the largest coin value <= credit.
  - Drive ret one-hot with hop_req=1 -> CHG_WAIT.
  - If credit is nonzero but below COIN0_VAL, clear credit (forfeit), pulse vend_done if this is a sale, go to IDLE.
- CHG_WAIT: hold ret/hop_req until hop_ack.
  - On hop_ack: subtract the coin value, deassert hop_req and set ret=0 -> CHG_GAP.
- CHG_GAP: one idle cycle (hop_req low between coins).
  - credit>0 -> CHG_ISSUE.
  - credit=0 -> pulse vend_done (sale path only) -> IDLE.
- Acks: disp_ack outside DISP_WAIT and hop_ack outside CHG_WAIT are ignored.
- Arithmetic: unsigned, CREDIT_W bits. Credit never exceeds MAX_CREDIT and never underflows.

Optional Feature:
- VEND_STOCK_EN defined: adds two 4-bit stock counters.
  - Reset value 4'd15.
  - Decremented on the disp_ack of the matching product.
  - vend_req for a product with stock 0 is ignored like insufficient credit.
  - Adds output port sold_out [1:0], bit n high when stock n = 0.
- VEND_STOCK_EN undefined: no counters and no sold_out port; stock is unlimited.

Test Plan:
- Reset credit, then coins 001,010 -> credit 15; vend_req choice=0 -> disp_req=1, disp_sel=0; disp_ack -> vend_done pulse, credit 0, no hop_req.
- Coin 100 (credit 25), vend_req choice=1 -> dispense, then one hop_req with ret=001 (5); hop_ack -> credit 0, vend_done.
- Credit 10, vend_req choice=1 -> ignored, credit stays 10, busy stays 0; cancel -> ret=010 once, credit 0, no vend_done.
- Coins 100x4 (credit 100), coin 001 -> coin_reject pulse, credit 100; coin 3'b011 -> coin_reject.
- Credit 20, vend_req choice=0, hold disp_ack=0 for 64 cycles -> fault=1, disp_req=0, refund ret=010 then 010 (credit 20 restored, paid out 10+10).
- Assert rst=0 mid-CHG_WAIT -> hop_req=0, ret=0, credit=0, state IDLE immediately without a clock edge.

Source files
------------

// File: rtl/vend_sequencer_if.sv
// Vending sequencer bus: coin/keypad front end plus dispenser and hopper handshakes.
// Pure wiring, no latency; the dispenser and hopper hold off progress through their acks.
// Optional VEND_STOCK_EN adds the sold_out status bits.
interface vend_sequencer_if #(
  parameter int CREDIT_W = 8
);
  logic [2:0]          coin;
  logic                coin_reject;
  logic                vend_req;
  logic                choice;
  logic                cancel;
  logic                disp_req;
  logic                disp_sel;
  logic                disp_ack;
  logic                hop_req;
  logic [2:0]          ret;
  logic                hop_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                vend_done;
  logic                fault;
`ifdef VEND_STOCK_EN
  logic [1:0]          sold_out;
`endif

  // Sequencer side
  modport slave (
    input  coin, vend_req, choice, cancel, disp_ack, hop_ack,
    output coin_reject, disp_req, disp_sel, hop_req, ret, credit, busy, vend_done, fault
`ifdef VEND_STOCK_EN
    , sold_out
`endif
  );

  // Front end / mechanics side
  modport master (
    output coin, vend_req, choice, cancel, disp_ack, hop_ack,
    input  coin_reject, disp_req, disp_sel, hop_req, ret, credit, busy, vend_done, fault
`ifdef VEND_STOCK_EN
    , sold_out
`endif
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, price check, dispense, coin-by-coin change.
// All outputs registered: one cycle from input strobe/ack to output change.
// Dispenser and hopper stall the FSM via req/ack; coins arriving while busy are rejected.
// Optional feature macro: VEND_STOCK_EN (per-product 4-bit stock counters, sold_out port).
module vend_sequencer #(
  parameter int COIN0_VAL    = 5,
  parameter int COIN1_VAL    = 10,
  parameter int COIN2_VAL    = 25,
  parameter int PRICE0       = 15,
  parameter int PRICE1       = 20,
  parameter int CREDIT_W     = 8,
  parameter int MAX_CREDIT   = 100,
  parameter int DISP_TIMEOUT = 64
) (
  input logic             clk,
  input logic             rst,
  vend_sequencer_if.slave bus
);

  typedef logic [CREDIT_W-1:0] credit_t;
  typedef logic [CREDIT_W:0]   wide_t;
  localparam int CNT_W = $clog2(DISP_TIMEOUT + 1);
  typedef logic [CNT_W-1:0]    cnt_t;

  localparam credit_t CV0      = credit_t'(COIN0_VAL);
  localparam credit_t CV1      = credit_t'(COIN1_VAL);
  localparam credit_t CV2      = credit_t'(COIN2_VAL);
  localparam credit_t PR0      = credit_t'(PRICE0);
  localparam credit_t PR1      = credit_t'(PRICE1);
  localparam wide_t   MAX_W    = wide_t'(MAX_CREDIT);
  localparam cnt_t    TMO_LAST = cnt_t'(DISP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, DISP_WAIT, CHG_ISSUE, CHG_WAIT, CHG_GAP
  } state_t;

  state_t     state_q, state_d;
  credit_t    credit_q, credit_d;
  cnt_t       cnt_q, cnt_d;
  logic       disp_req_q, disp_req_d;
  logic       disp_sel_q, disp_sel_d;
  logic       hop_req_q, hop_req_d;
  logic [2:0] ret_q, ret_d;
  logic       busy_q, busy_d;
  logic       vend_done_q, vend_done_d;
  logic       coin_reject_q, coin_reject_d;
  logic       fault_q, fault_d;
  // Set when the current change run belongs to a completed sale (vend_done owed at the end)
  logic       sale_q, sale_d;
`ifdef VEND_STOCK_EN
  logic [3:0] stock0_q, stock0_d;
  logic [3:0] stock1_q, stock1_d;
`endif

  credit_t coin_val;
  logic    coin_onehot;
  wide_t   coin_sum;
  credit_t price_sel;
  credit_t price_disp;
  credit_t ret_val;
  logic    vend_ok;

  // Decode the coin strobe, the selected price and the value of the coin being paid out
  always_comb begin
    coin_val    = '0;
    coin_onehot = 1'b1;
    case (bus.coin)
      3'b001:  coin_val = CV0;
      3'b010:  coin_val = CV1;
      3'b100:  coin_val = CV2;
      default: coin_onehot = 1'b0;
    endcase
    coin_sum   = {1'b0, credit_q} + {1'b0, coin_val};
    price_sel  = bus.choice ? PR1 : PR0;
    price_disp = disp_sel_q ? PR1 : PR0;
    ret_val    = '0;
    case (ret_q)
      3'b001:  ret_val = CV0;
      3'b010:  ret_val = CV1;
      3'b100:  ret_val = CV2;
      default: ret_val = '0;
    endcase
`ifdef VEND_STOCK_EN
    vend_ok = (credit_q >= price_sel) && (bus.choice ? (stock1_q != 4'd0) : (stock0_q != 4'd0));
`else
    vend_ok = (credit_q >= price_sel);
`endif
  end

  // Next-state and next-output logic for the transaction FSM
  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    cnt_d         = cnt_q;
    disp_req_d    = disp_req_q;
    disp_sel_d    = disp_sel_q;
    hop_req_d     = hop_req_q;
    ret_d         = ret_q;
    fault_d       = fault_q;
    sale_d        = sale_q;
    vend_done_d   = 1'b0;
    // Any coin is bounced unless the IDLE coin path below takes it
    coin_reject_d = (bus.coin != 3'b000);
`ifdef VEND_STOCK_EN
    stock0_d      = stock0_q;
    stock1_d      = stock1_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cancel && (credit_q != '0)) begin
          sale_d  = 1'b0;
          state_d = CHG_ISSUE;
        end else if (bus.vend_req && vend_ok) begin
          credit_d   = credit_q - price_sel;
          disp_sel_d = bus.choice;
          disp_req_d = 1'b1;
          cnt_d      = '0;
          sale_d     = 1'b1;
          state_d    = DISP_WAIT;
        end else if (bus.coin != 3'b000) begin
          if (coin_onehot && (coin_sum <= MAX_W)) begin
            credit_d      = coin_sum[CREDIT_W-1:0];
            coin_reject_d = 1'b0;
          end
        end
      end
      DISP_WAIT: begin
        if (bus.disp_ack) begin
          disp_req_d = 1'b0;
`ifdef VEND_STOCK_EN
          if (!disp_sel_q && (stock0_q != 4'd0)) stock0_d = stock0_q - 4'd1;
          if (disp_sel_q && (stock1_q != 4'd0))  stock1_d = stock1_q - 4'd1;
`endif
          if (credit_q != '0) begin
            state_d = CHG_ISSUE;
          end else begin
            vend_done_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          // Dispenser never answered: give the price back and refund everything
          disp_req_d = 1'b0;
          fault_d    = 1'b1;
          credit_d   = credit_q + price_disp;
          sale_d     = 1'b0;
          state_d    = CHG_ISSUE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      CHG_ISSUE: begin
        // Coin values are assumed ordered COIN2 > COIN1 > COIN0 (largest first)
        if (credit_q >= CV2) begin
          ret_d     = 3'b100;
          hop_req_d = 1'b1;
          state_d   = CHG_WAIT;
        end else if (credit_q >= CV1) begin
          ret_d     = 3'b010;
          hop_req_d = 1'b1;
          state_d   = CHG_WAIT;
        end else if (credit_q >= CV0) begin
          ret_d     = 3'b001;
          hop_req_d = 1'b1;
          state_d   = CHG_WAIT;
        end else begin
          // Remainder smaller than any coin is forfeited
          credit_d    = '0;
          vend_done_d = sale_q;
          state_d     = IDLE;
        end
      end
      CHG_WAIT: begin
        if (bus.hop_ack) begin
          credit_d  = credit_q - ret_val;
          hop_req_d = 1'b0;
          ret_d     = 3'b000;
          state_d   = CHG_GAP;
        end
      end
      CHG_GAP: begin
        if (credit_q != '0) begin
          state_d = CHG_ISSUE;
        end else begin
          vend_done_d = sale_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      cnt_q         <= '0;
      disp_req_q    <= 1'b0;
      disp_sel_q    <= 1'b0;
      hop_req_q     <= 1'b0;
      ret_q         <= 3'b000;
      busy_q        <= 1'b0;
      vend_done_q   <= 1'b0;
      coin_reject_q <= 1'b0;
      fault_q       <= 1'b0;
      sale_q        <= 1'b0;
`ifdef VEND_STOCK_EN
      stock0_q      <= 4'd15;
      stock1_q      <= 4'd15;
`endif
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      cnt_q         <= cnt_d;
      disp_req_q    <= disp_req_d;
      disp_sel_q    <= disp_sel_d;
      hop_req_q     <= hop_req_d;
      ret_q         <= ret_d;
      busy_q        <= busy_d;
      vend_done_q   <= vend_done_d;
      coin_reject_q <= coin_reject_d;
      fault_q       <= fault_d;
      sale_q        <= sale_d;
`ifdef VEND_STOCK_EN
      stock0_q      <= stock0_d;
      stock1_q      <= stock1_d;
`endif
    end
  end

  assign bus.coin_reject = coin_reject_q;
  assign bus.disp_req    = disp_req_q;
  assign bus.disp_sel    = disp_sel_q;
  assign bus.hop_req     = hop_req_q;
  assign bus.ret         = ret_q;
  assign bus.credit      = credit_q;
  assign bus.busy        = busy_q;
  assign bus.vend_done   = vend_done_q;
  assign bus.fault       = fault_q;
`ifdef VEND_STOCK_EN
  assign bus.sold_out    = {(stock1_q == 4'd0), (stock0_q == 4'd0)};
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: vector table plus timeout and async-reset sequences.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Hopper acks are driven by the bench with a bounded wait for hop_req.
module tb_vend_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vend_sequencer_if #(.CREDIT_W(8)) vif ();

  vend_sequencer dut (
    .clk (clk),
    .rst (rst_n),
    .bus (vif)
  );

  typedef struct {
    logic [2:0] coin;
    logic       vend_req;
    logic       choice;
    logic       cancel;
    logic       disp_ack;
    logic       hop_ack;
    logic [7:0] e_credit;
    logic       e_disp_req;
    logic       e_disp_sel;
    logic       e_hop_req;
    logic [2:0] e_ret;
    logic       e_busy;
    logic       e_vend_done;
    logic       e_coin_reject;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(input logic [2:0] c, input logic vr, input logic ch, input logic cn,
                             input logic da, input logic ha, input logic [7:0] cr, input logic dq,
                             input logic ds, input logic hq, input logic [2:0] rt, input logic bz,
                             input logic vd, input logic rj);
    vec_t r;
    r.coin = c; r.vend_req = vr; r.choice = ch; r.cancel = cn; r.disp_ack = da; r.hop_ack = ha;
    r.e_credit = cr; r.e_disp_req = dq; r.e_disp_sel = ds; r.e_hop_req = hq; r.e_ret = rt;
    r.e_busy = bz; r.e_vend_done = vd; r.e_coin_reject = rj;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    vif.coin = 3'b000; vif.vend_req = 1'b0; vif.choice = 1'b0; vif.cancel = 1'b0;
    vif.disp_ack = 1'b0; vif.hop_ack = 1'b0;
  endtask

  // Wait (bounded) for a change coin, check it, acknowledge it and check the credit after
  task automatic take_coin(input string nm, input logic [2:0] exp_ret, input logic [7:0] exp_cr);
    int waited = 0;
    while (vif.hop_req !== 1'b1 && waited < 10) begin
      cyc();
      waited++;
    end
    chk({nm, "_hop_req"}, 32'(vif.hop_req), 32'd1);
    chk({nm, "_ret"}, 32'(vif.ret), 32'(exp_ret));
    vif.hop_ack = 1'b1;
    cyc();
    vif.hop_ack = 1'b0;
    chk({nm, "_credit"}, 32'(vif.credit), 32'(exp_cr));
    chk({nm, "_hop_drop"}, {vif.hop_req, vif.ret}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] act, exp;
    idle_inputs();

    //            coin   vr ch cn da ha  credit dq ds hq ret    bz vd rj
    // sale with exact credit
    tv.push_back(v(3'b001,0,0,0,0,0, 8'd5,  0,0,0,3'b000,0,0,0));
    tv.push_back(v(3'b010,0,0,0,0,0, 8'd15, 0,0,0,3'b000,0,0,0));
    tv.push_back(v(3'b000,1,0,0,0,0, 8'd0,  1,0,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd0,  1,0,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,1,0, 8'd0,  0,0,0,3'b000,0,1,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd0,  0,0,0,3'b000,0,0,0));
    // sale with one change coin
    tv.push_back(v(3'b100,0,0,0,0,0, 8'd25, 0,0,0,3'b000,0,0,0));
    tv.push_back(v(3'b000,1,1,0,0,0, 8'd5,  1,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,1,0, 8'd5,  0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd5,  0,1,1,3'b001,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd5,  0,1,1,3'b001,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd0,  0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd0,  0,1,0,3'b000,0,1,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd0,  0,1,0,3'b000,0,0,0));
    // insufficient credit, then cancel refund
    tv.push_back(v(3'b010,0,0,0,0,0, 8'd10, 0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b000,1,1,0,0,0, 8'd10, 0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b000,0,0,1,0,0, 8'd10, 0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd10, 0,1,1,3'b010,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd0,  0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd0,  0,1,0,3'b000,0,0,0));
    // fill to MAX_CREDIT, then overflow and non-one-hot rejects
    tv.push_back(v(3'b100,0,0,0,0,0, 8'd25, 0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b100,0,0,0,0,0, 8'd50, 0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b100,0,0,0,0,0, 8'd75, 0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b100,0,0,0,0,0, 8'd100,0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b001,0,0,0,0,0, 8'd100,0,1,0,3'b000,0,0,1));
    tv.push_back(v(3'b011,0,0,0,0,0, 8'd100,0,1,0,3'b000,0,0,1));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd100,0,1,0,3'b000,0,0,0));
    // cancel beats a coin; coin during payout is rejected; refund 4x25
    tv.push_back(v(3'b001,0,0,1,0,0, 8'd100,0,1,0,3'b000,1,0,1));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd100,0,1,1,3'b100,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd75, 0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b001,0,0,0,0,0, 8'd75, 0,1,0,3'b000,1,0,1));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd75, 0,1,1,3'b100,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd50, 0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd50, 0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd50, 0,1,1,3'b100,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd25, 0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd25, 0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd25, 0,1,1,3'b100,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,1, 8'd0,  0,1,0,3'b000,1,0,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd0,  0,1,0,3'b000,0,0,0));
    // cancel at zero credit ignored (coin taken); stray acks ignored; vend beats coin
    tv.push_back(v(3'b001,0,0,1,0,0, 8'd5,  0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b000,0,0,0,1,1, 8'd5,  0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b010,0,0,0,0,0, 8'd15, 0,1,0,3'b000,0,0,0));
    tv.push_back(v(3'b001,1,0,0,0,0, 8'd0,  1,0,0,3'b000,1,0,1));
    tv.push_back(v(3'b000,0,0,0,1,0, 8'd0,  0,0,0,3'b000,0,1,0));
    tv.push_back(v(3'b000,0,0,0,0,0, 8'd0,  0,0,0,3'b000,0,0,0));

    // Reset state
    repeat (2) cyc();
    chk("reset_outputs", {vif.credit, vif.disp_req, vif.disp_sel, vif.hop_req, vif.ret, vif.busy,
                          vif.vend_done, vif.coin_reject, vif.fault}, 32'd0);
    rst_n = 1'b1;
    cyc();

    // Vector table
    for (int i = 0; i < tv.size(); i++) begin
      vif.coin = tv[i].coin; vif.vend_req = tv[i].vend_req; vif.choice = tv[i].choice;
      vif.cancel = tv[i].cancel; vif.disp_ack = tv[i].disp_ack; vif.hop_ack = tv[i].hop_ack;
      cyc();
      idle_inputs();
      act = {vif.credit, vif.disp_req, vif.disp_sel, vif.hop_req, vif.ret, vif.busy,
             vif.vend_done, vif.coin_reject, vif.fault};
      exp = {tv[i].e_credit, tv[i].e_disp_req, tv[i].e_disp_sel, tv[i].e_hop_req, tv[i].e_ret,
             tv[i].e_busy, tv[i].e_vend_done, tv[i].e_coin_reject, 1'b0};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL row%0d: got cr=%0d dq=%b ds=%b hq=%b ret=%b bz=%b vd=%b rj=%b ft=%b, expected cr=%0d dq=%b ds=%b hq=%b ret=%b bz=%b vd=%b rj=%b ft=%b",
                 i, act[17:10], act[9], act[8], act[7], act[6:4], act[3], act[2], act[1], act[0],
                 exp[17:10], exp[9], exp[8], exp[7], exp[6:4], exp[3], exp[2], exp[1], exp[0]);
      end
    end

    // Dispense timeout: credit 20, buy product 0, dispenser silent
    vif.coin = 3'b010; cyc(); cyc(); vif.coin = 3'b000;
    chk("tmo_credit20", 32'(vif.credit), 32'd20);
    vif.vend_req = 1'b1; vif.choice = 1'b0; cyc(); idle_inputs();
    chk("tmo_vend_credit", 32'(vif.credit), 32'd5);
    chk("tmo_disp_req", 32'(vif.disp_req), 32'd1);
    repeat (63) cyc();
    chk("tmo_fault_early", {vif.fault, vif.disp_req}, 32'b01);
    cyc();
    chk("tmo_fault_set", {vif.fault, vif.disp_req, vif.busy}, 32'b101);
    chk("tmo_credit_restored", 32'(vif.credit), 32'd20);
    take_coin("tmo_coin1", 3'b010, 8'd10);
    take_coin("tmo_coin2", 3'b010, 8'd0);
    cyc();
    chk("tmo_end", {vif.busy, vif.vend_done, vif.fault}, 32'b001);

    // Asynchronous reset in the middle of a change handshake
    vif.coin = 3'b001; cyc(); vif.coin = 3'b000;
    vif.cancel = 1'b1; cyc(); vif.cancel = 1'b0;
    cyc();
    chk("arst_pre_hop", {vif.hop_req, vif.ret}, 32'b1001);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {vif.hop_req, vif.ret, vif.credit, vif.busy, vif.fault}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk("arst_after", {vif.credit, vif.busy, vif.hop_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
